sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single 8-bit SDRAM controller port between three requesters: OSD ROM/cartridge download (ioctl), the Z80 RAM path (after svi_mapper), and the cassette byte reader.
- This lets CAS images live in SDRAM instead of block RAM.
- Sits between those requesters and the sdram module, in the clk_sys domain.
- Serialises accesses, offsets cassette addresses into a dedicated SDRAM region, and returns read data with per-requester acknowledges.

Parameters:
- AW, 22, SDRAM byte address width on all ports.
- CAS_BASE, 22'h040000, SDRAM base added to cassette byte addresses.
- TIMEOUT, 255, clk_i cycles waited for mem_ack before aborting an access.

Ports:
- clk_i  in  1  system clock (clk_sys).
- reset_n_i  in  1  asynchronous active-low reset.
- dl_req_i  in  1  download write request; level, held until dl_ack_o.
- dl_addr_i  in  AW  download byte address.
- dl_data_i  in  8  download write data.
- dl_ack_o  out  1  one-cycle pulse: download write completed.
- cpu_req_i  in  1  CPU request; level, held until cpu_ack_o.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  AW  CPU byte address (mapped).
- cpu_data_i  in  8  CPU write data.
- cpu_data_o  out  8  CPU read data; valid from cpu_ack_o until the next CPU read completes.
- cpu_ack_o  out  1  one-cycle completion pulse.
- cas_req_i  in  1  cassette read request; level, held until cas_ack_o.
- cas_addr_i  in  AW  cassette byte offset.
- cas_data_o  out  8  cassette read data; same validity rule as cpu_data_o.
- cas_ack_o  out  1  one-cycle completion pulse.
- mem_req_o  out  1  one-cycle start pulse to the SDRAM controller.
- mem_we_o  out  1  write qualifier; stable from mem_req_o until mem_ack_i.
- mem_addr_o  out  AW  address; stable from mem_req_o until mem_ack_i.
- mem_data_o  out  8  write data; stable from mem_req_o until mem_ack_i.
- mem_data_i  in  8  read data, valid in the mem_ack_i cycle.
- mem_ack_i  in  1  one-cycle completion pulse from the controller.
- timeout_o  out  1  sticky flag: an access was aborted; cleared only by reset.

Behaviour:
- Reset (async, reset_n_i=0): state IDLE; all acks, mem_req_o, mem_we_o and timeout_o are 0; mem_addr_o, mem_data_o, cpu_data_o and cas_data_o are 0; round-robin pointer = CPU-preferred.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample requests each cycle and pick a grant.
  - dl_req_i wins unconditionally.
  - Otherwise, if only one of cpu/cas requests, that one wins.
  - If both request, the one not granted last wins (round-robin pointer).
  - Latch grant, we, addr and data; go to ISSUE.
  - Cassette address = CAS_BASE + cas_addr_i, truncated to AW bits (wraps modulo 2^AW). Cassette accesses are always reads.
  - Download accesses are always writes.
- ISSUE: mem_req_o=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: hold mem_* outputs.
  - On mem_ack_i: for reads, register mem_data_i into the granted requester's data_o; go to DONE.
  - If the counter reaches TIMEOUT without mem_ack_i: set timeout_o; go to DONE without updating data_o. The requester still gets its ack so the CPU never hangs.
- DONE: pulse the granted requester's ack for one cycle; update the round-robin pointer only for cpu/cas grants; go to IDLE.
  - The requester drops req on the cycle after its ack. IDLE therefore ignores a requester's req in the cycle immediately following its own ack.
- Latency: req seen in IDLE at edge N → mem_req_o at N+1 → ack at (mem_ack_i edge)+1. Minimum request-to-ack is 4 cycles when mem_ack_i arrives the cycle after mem_req_o.
- Only one access is outstanding at a time; mem_req_o is never asserted outside ISSUE.
- mem_ack_i outside WAIT is ignored.
- A request dropped mid-access does not abort it; the access completes and the ack still pulses.
- Reset asserted mid-access aborts immediately with no ack. The SDRAM controller is reset by the same source.
- The download path starves cpu/cas by design, because the CPU is held in reset during ROM downloads.

Test Plan:
- Single CPU write to 0x00123 with data 0xA5 → mem_req_o one cycle with we=1, addr 0x00123, data 0xA5 → cpu_ack_o one pulse. A CPU read of the same address then returns cpu_data_o=0xA5.
- Cassette read of offset 0x0010, memory model returning 0x3C → mem_addr_o = 0x040010, we=0 → cas_data_o=0x3C and cas_ack_o pulses; cpu_data_o is unchanged.
- cpu_req and cas_req held continuously → grants alternate CPU, CAS, CPU, CAS; the first grant goes to CPU after reset.
- dl_req, cpu_req and cas_req asserted together → download is granted first. With dl_req held for 3 back-to-back writes, cpu/cas are granted only after dl_req drops.
- Memory model never acks; TIMEOUT=255 → timeout_o=1 and cpu_ack_o pulses 257 cycles after mem_req_o; cpu_data_o keeps its old value; the next access proceeds normally.
- reset_n_i pulsed low during WAIT → all outputs 0 asynchronously and no ack is emitted. After release, a cpu_req is served normally with CPU preferred.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter in front of the 8-bit SDRAM controller port: download writes,
// CPU reads/writes and cassette reads, one outstanding access at a time.
module sdram_port_arbiter #(
  parameter int              AW       = 22,
  parameter logic [AW-1:0]   CAS_BASE = 22'h040000,
  parameter int              TIMEOUT  = 255
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          dl_req_i,
  input  logic [AW-1:0] dl_addr_i,
  input  logic [7:0]    dl_data_i,
  output logic          dl_ack_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_data_i,
  output logic [7:0]    cpu_data_o,
  output logic          cpu_ack_o,
  input  logic          cas_req_i,
  input  logic [AW-1:0] cas_addr_i,
  output logic [7:0]    cas_data_o,
  output logic          cas_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_data_o,
  input  logic [7:0]    mem_data_i,
  input  logic          mem_ack_i,
  output logic          timeout_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_DL, G_CPU, G_CAS} gnt_t;

  state_t        state_reg, state_next;
  gnt_t          gnt_reg, gnt_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [7:0]    wdata_reg, wdata_next;
  logic [7:0]    cpu_data_reg, cpu_data_next;
  logic [7:0]    cas_data_reg, cas_data_next;
  logic          timeout_reg, timeout_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          cas_pref_reg, cas_pref_next;
  logic          hold_reg, hold_next;
  logic [AW-1:0] cas_addr_full;

  assign cas_addr_full = CAS_BASE + cas_addr_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg    <= S_IDLE;
      gnt_reg      <= G_NONE;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      cpu_data_reg <= '0;
      cas_data_reg <= '0;
      timeout_reg  <= 1'b0;
      cnt_reg      <= '0;
      cas_pref_reg <= 1'b0;
      hold_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      cpu_data_reg <= cpu_data_next;
      cas_data_reg <= cas_data_next;
      timeout_reg  <= timeout_next;
      cnt_reg      <= cnt_next;
      cas_pref_reg <= cas_pref_next;
      hold_reg     <= hold_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    cpu_data_next = cpu_data_reg;
    cas_data_next = cas_data_reg;
    timeout_next  = timeout_reg;
    cnt_next      = cnt_reg;
    cas_pref_next = cas_pref_reg;
    hold_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // The first IDLE cycle after an ack grants nothing: the acked requester
        // is still dropping its req, and a held download keeps its priority.
        if (!hold_reg) begin
          if (dl_req_i) begin
            gnt_next   = G_DL;
            we_next    = 1'b1;
            addr_next  = dl_addr_i;
            wdata_next = dl_data_i;
            state_next = S_ISSUE;
          end else if (cpu_req_i && !(cas_req_i && cas_pref_reg)) begin
            gnt_next   = G_CPU;
            we_next    = cpu_we_i;
            addr_next  = cpu_addr_i;
            wdata_next = cpu_data_i;
            state_next = S_ISSUE;
          end else if (cas_req_i) begin
            gnt_next   = G_CAS;
            we_next    = 1'b0;
            addr_next  = cas_addr_full;
            wdata_next = '0;
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          if (!we_reg && gnt_reg == G_CPU) cpu_data_next = mem_data_i;
          if (!we_reg && gnt_reg == G_CAS) cas_data_next = mem_data_i;
          state_next = S_DONE;
        end else if (cnt_reg == CW'(TIMEOUT)) begin
          timeout_next = 1'b1;
          state_next   = S_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        if (gnt_reg == G_CPU) cas_pref_next = 1'b1;
        else if (gnt_reg == G_CAS) cas_pref_next = 1'b0;
        hold_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign mem_req_o  = (state_reg == S_ISSUE);
  assign mem_we_o   = we_reg;
  assign mem_addr_o = addr_reg;
  assign mem_data_o = wdata_reg;
  assign dl_ack_o   = (state_reg == S_DONE) && (gnt_reg == G_DL);
  assign cpu_ack_o  = (state_reg == S_DONE) && (gnt_reg == G_CPU);
  assign cas_ack_o  = (state_reg == S_DONE) && (gnt_reg == G_CAS);
  assign cpu_data_o = cpu_data_reg;
  assign cas_data_o = cas_data_reg;
  assign timeout_o  = timeout_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: table vectors, hand sequences for
// arbitration/timeout/reset, and random traffic against a byte-array reference.
module tb_sdram_port_arbiter;
  localparam int AW       = 22;
  localparam int TIMEOUT  = 255;
  localparam int CAS_BASE = 'h040000;
  localparam int ASPAN    = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dl_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, cas_req = 1'b0;
  logic [21:0] dl_addr = '0, cpu_addr = '0, cas_addr = '0;
  logic [7:0]  dl_data = '0, cpu_wdata = '0;
  logic [7:0]  cpu_data_o, cas_data_o;
  logic        dl_ack, cpu_ack, cas_ack;
  logic        mem_req_o, mem_we_o;
  logic [21:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic [7:0]  mem_data_i;
  logic        mem_ack_i;
  logic        timeout_o;

  sdram_port_arbiter #(.AW(AW), .CAS_BASE(22'h040000), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .dl_req_i(dl_req), .dl_addr_i(dl_addr), .dl_data_i(dl_data), .dl_ack_o(dl_ack),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_data_o(cpu_data_o), .cpu_ack_o(cpu_ack),
    .cas_req_i(cas_req), .cas_addr_i(cas_addr), .cas_data_o(cas_data_o), .cas_ack_o(cas_ack),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SDRAM stand-in: stores writes, answers mem_lat cycles after mem_req_o, or never.
  bit         mem_dead = 1'b0;
  int         mem_lat = 1;
  logic [7:0] sdram [int];
  int         rem = 0;
  bit         p_we;
  int         p_addr;

  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = 8'h00;
    forever begin
      tick();
      mem_ack_i  = 1'b0;
      mem_data_i = 8'($urandom);
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          mem_ack_i = 1'b1;
          if (!p_we) mem_data_i = sdram.exists(p_addr) ? sdram[p_addr] : 8'h00;
        end
      end
      if (mem_req_o && rst_n) begin
        p_we   = mem_we_o;
        p_addr = int'(mem_addr_o);
        if (mem_we_o) sdram[p_addr] = mem_data_o;
        if (!mem_dead) rem = mem_lat;
      end
    end
  end

  // Protocol watch: at most one ack per cycle, mem_req_o never longer than one cycle.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(dl_ack) + int'(cpu_ack) + int'(cas_ack) > 1) begin
        n_bad++;
        $display("FAIL ack_onehot: actual %b%b%b, required at most one", dl_ack, cpu_ack, cas_ack);
      end
      if (prev_req && mem_req_o) begin
        n_bad++;
        $display("FAIL mem_req_pulse: actual 2+ cycles, required 1");
      end
    end
    prev_req <= mem_req_o;
  end

  // Reference model: byte memory, cassette mapping, round-robin preference (1=CPU, 2=CAS).
  logic [7:0] ref_mem [int];
  int rr_pref = 1;

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int cas_map(input int off);
    return (CAS_BASE + off) % ASPAN;
  endfunction

  function automatic int who_ack();
    if (dl_ack)  return 0;
    if (cpu_ack) return 1;
    if (cas_ack) return 2;
    return -1;
  endfunction

  task automatic drop_all();
    dl_req = 1'b0; cpu_req = 1'b0; cas_req = 1'b0;
  endtask

  // One isolated access; kind 0=download, 1=CPU, 2=cassette.
  task automatic access(input int kind, input bit we, input int addr, input logic [7:0] wd,
                        input int exp_addr, input logic [7:0] exp_rd, input bit to_exp,
                        input string tag);
    bit         we_eff, got;
    int         cyc;
    logic [7:0] old_cpu, old_cas, exp_cpu, exp_cas;
    logic [2:0] exp_ack;
    we_eff  = (kind == 0) ? 1'b1 : (kind == 2) ? 1'b0 : we;
    old_cpu = cpu_data_o;
    old_cas = cas_data_o;
    case (kind)
      0: begin dl_req = 1'b1; dl_addr = addr[21:0]; dl_data = wd; end
      1: begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr[21:0]; cpu_wdata = wd; end
      default: begin cas_req = 1'b1; cas_addr = addr[21:0]; end
    endcase
    got = 1'b0; cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mem_req_o) begin got = 1'b1; cyc = i; break; end
    end
    check({tag, " req_latency"}, cyc, 1);
    if (got) begin
      check({tag, " mem_addr"}, mem_addr_o, exp_addr);
      check({tag, " mem_we"}, mem_we_o, we_eff);
      if (we_eff) check({tag, " mem_wdata"}, mem_data_o, wd);
    end
    if (we_eff && !to_exp) ref_mem[exp_addr] = wd;
    got = 1'b0; cyc = 0;
    for (int i = 1; i <= TIMEOUT + 20; i++) begin
      tick();
      if (dl_ack || cpu_ack || cas_ack) begin got = 1'b1; cyc = i; break; end
    end
    check({tag, " ack_latency"}, cyc, to_exp ? TIMEOUT + 2 : mem_lat + 1);
    exp_ack = (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001;
    check({tag, " ack_who"}, {dl_ack, cpu_ack, cas_ack}, exp_ack);
    exp_cpu = (kind == 1 && !we_eff && !to_exp) ? exp_rd : old_cpu;
    exp_cas = (kind == 2 && !to_exp) ? exp_rd : old_cas;
    check({tag, " cpu_data"}, cpu_data_o, exp_cpu);
    check({tag, " cas_data"}, cas_data_o, exp_cas);
    if (kind == 1) rr_pref = 2;
    if (kind == 2) rr_pref = 1;
    tick();
    drop_all();
    check({tag, " ack_pulse"}, {dl_ack, cpu_ack, cas_ack}, 3'b000);
    tick();
    $display("txn %s kind=%0d we=%0d addr=%06h wd=%02h cyc=%0d", tag, kind, we_eff, addr, wd, cyc);
  endtask

  // CPU read and cassette read raised together; order follows the round-robin model.
  task automatic contend(input int c_addr, input int c_off, input string tag);
    int w, exp_w;
    bit got;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = c_addr[21:0];
    cas_req = 1'b1; cas_addr = c_off[21:0];
    for (int k = 0; k < 2; k++) begin
      exp_w = (k == 0) ? rr_pref : 3 - rr_pref;
      got = 1'b0; w = -1;
      for (int i = 0; i < 40; i++) begin
        tick();
        w = who_ack();
        if (w >= 0) begin got = 1'b1; break; end
      end
      check({tag, " order"}, w, exp_w);
      if (w == 1) check({tag, " cpu_data"}, cpu_data_o, ref_rd(c_addr));
      if (w == 2) check({tag, " cas_data"}, cas_data_o, ref_rd(cas_map(c_off)));
      tick();
      if (w == 1) cpu_req = 1'b0;
      else if (w == 2) cas_req = 1'b0;
      else drop_all();
    end
    drop_all();
    tick();
    $display("txn %s contend cpu=%06h cas_off=%06h first=%0d", tag, c_addr, c_off, rr_pref);
  endtask

  typedef struct {
    int         kind;
    bit         we;
    int         addr;
    logic [7:0] wd;
    int         exp_maddr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [11];
  int   pool [8] = '{'h00123, 'h000200, 'h040010, 'h03FFF0, 'h1A2B3C, 'h3FFFFF, 'h040000, 'h000001};

  initial begin
    int ord [$];
    int exp_ord [5];
    int n, ndl, w, k, off, a;
    logic [7:0] d;

    tbl[0]  = '{1, 1'b1, 'h00123,  8'hA5, 'h00123,  8'h00};
    tbl[1]  = '{1, 1'b0, 'h00123,  8'h00, 'h00123,  8'hA5};
    tbl[2]  = '{2, 1'b0, 'h00010,  8'h00, 'h040010, 8'h3C};
    tbl[3]  = '{0, 1'b1, 'h03FFF0, 8'hC3, 'h03FFF0, 8'h00};
    tbl[4]  = '{2, 1'b0, 'h3FFFF0, 8'h00, 'h03FFF0, 8'hC3};
    tbl[5]  = '{1, 1'b0, 'h03FFF0, 8'h00, 'h03FFF0, 8'hC3};
    tbl[6]  = '{1, 1'b0, 'h2AAAAA, 8'h00, 'h2AAAAA, 8'h00};
    tbl[7]  = '{0, 1'b1, 'h3FFFFF, 8'h9E, 'h3FFFFF, 8'h00};
    tbl[8]  = '{2, 1'b0, 'h3BFFFF, 8'h00, 'h3FFFFF, 8'h9E};
    tbl[9]  = '{1, 1'b1, 'h000000, 8'h11, 'h000000, 8'h00};
    tbl[10] = '{1, 1'b0, 'h000000, 8'h00, 'h000000, 8'h11};
    sdram['h040010]   = 8'h3C;
    ref_mem['h040010] = 8'h3C;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst mem_req", mem_req_o, 0);
    check("rst acks", {dl_ack, cpu_ack, cas_ack}, 0);
    check("rst mem_we/addr/data", {mem_we_o, mem_addr_o, mem_data_o}, 0);
    check("rst data_o", {cpu_data_o, cas_data_o}, 0);
    check("rst timeout", timeout_o, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Continuous cpu+cas requests alternate, CPU first after reset
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h000400;
    cas_req = 1'b1; cas_addr = 22'h000010;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      tick();
      w = who_ack();
      if (w >= 0) begin
        check($sformatf("rr grant%0d", n), w, (n % 2 == 0) ? 1 : 2);
        n++;
        if (n == 4) begin tick(); drop_all(); end
      end
    end
    check("rr grant count", n, 4);
    rr_pref = 1;
    tick();
    $display("txn rr_seq grants=%0d", n);

    // Download held for three writes starves cpu/cas, then they proceed in RR order
    exp_ord = '{0, 0, 0, 1, 2};
    dl_req = 1'b1; dl_addr = 22'h000300; dl_data = 8'h77;
    cpu_req = 1'b1; cpu_addr = 22'h000300;
    cas_req = 1'b1; cas_addr = 22'h000010;
    ref_mem['h300] = 8'h77;
    n = 0; ndl = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      tick();
      w = who_ack();
      if (w >= 0) begin
        check($sformatf("dl_seq grant%0d", n), w, exp_ord[n]);
        if (w == 1) check("dl_seq cpu_data", cpu_data_o, 8'h77);
        if (w == 2) check("dl_seq cas_data", cas_data_o, 8'h3C);
        n++;
        if (w == 0) ndl++;
        tick();
        if (w == 0 && ndl == 3) dl_req = 1'b0;
        if (n == 5) drop_all();
      end
    end
    check("dl_seq grant count", n, 5);
    rr_pref = 1;
    tick();
    $display("txn dl_seq grants=%0d", n);

    // Table vectors with single-cycle memory latency
    mem_lat = 1;
    foreach (tbl[i])
      access(tbl[i].kind, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp_maddr,
             tbl[i].exp_rd, 1'b0, $sformatf("vec%0d", i));

    // Timeout: no mem_ack ever; ack still arrives, data kept, flag sticks
    check("timeout before", timeout_o, 0);
    mem_dead = 1'b1;
    access(1, 1'b0, 'h00123, 8'h00, 'h00123, 8'h00, 1'b1, "timeout");
    check("timeout flag", timeout_o, 1);
    mem_dead = 1'b0;
    access(1, 1'b0, 'h00123, 8'h00, 'h00123, 8'hA5, 1'b0, "after_timeout");
    check("timeout sticky", timeout_o, 1);

    // Random traffic against the reference model
    for (int t = 0; t < 120; t++) begin
      mem_lat = $urandom_range(1, 4);
      k   = $urandom_range(0, 9);
      a   = pool[$urandom_range(0, 7)];
      off = (pool[$urandom_range(0, 7)] - CAS_BASE + ASPAN) % ASPAN;
      d   = 8'($urandom);
      if (k < 2) contend(a, off, $sformatf("rnd%0d", t));
      else if (k < 4) access(0, 1'b1, a, d, a, 8'h00, 1'b0, $sformatf("rnd%0d", t));
      else if (k < 7) access(1, k[0], a, d, a, ref_rd(a), 1'b0, $sformatf("rnd%0d", t));
      else access(2, 1'b0, off, 8'h00, cas_map(off), ref_rd(cas_map(off)), 1'b0,
                  $sformatf("rnd%0d", t));
    end

    // Reset during WAIT: asynchronous clear, no ack, CPU preferred afterwards
    mem_lat = 1;
    access(1, 1'b0, 'h00123, 8'h00, 'h00123, ref_rd('h00123), 1'b0, "pre_reset");
    mem_dead = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h2F0F0F; cpu_wdata = 8'hFF;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_req_o) break;
    end
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst mem_req/we", {mem_req_o, mem_we_o}, 0);
    check("midrst mem_addr", mem_addr_o, 0);
    check("midrst mem_data", mem_data_o, 0);
    check("midrst data_o", {cpu_data_o, cas_data_o}, 0);
    check("midrst timeout", timeout_o, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dl_ack || cpu_ack || cas_ack) n++;
    end
    drop_all();
    rst_n = 1'b1;
    mem_dead = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dl_ack || cpu_ack || cas_ack) n++;
    end
    check("midrst no ack", n, 0);
    rr_pref = 1;
    $display("txn mid_reset acks=%0d", n);
    contend('h00123, 'h00010, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual no finish, required finish");
    $fatal(1);
  end

endmodule
